// File: rtl/pong_ball_engine.sv
// pong_ball_engine: Pong ball position/velocity, serve/score FSM, wall and paddle collisions, ball pixel mask.
//   Ports: clk, reset (sync, active-high); hcount/vcount pixel position; vsync (falling edge = frame tick);
//   paddle_l_y/paddle_r_y paddle top rows; serve request; ball_on registered pixel mask;
//   ball_x/ball_y ball top-left; score_l/score_r one-clk score pulses; state (0 IDLE,1 SERVE_WAIT,2 PLAY,3 SCORED).
//   Optional: define PONG_SPEEDUP_EN to bump |vx| by one (up to VEL_MAX) on every paddle hit.
module pong_ball_engine #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_X_L   = 8,
    parameter int PADDLE_X_R   = 624,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int VEL_W        = 4,
    parameter int VEL_INIT     = 2,
    parameter int VEL_MAX      = 6,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       vsync,
    input  logic [9:0] paddle_l_y,
    input  logic [9:0] paddle_r_y,
    input  logic       serve,
    output logic       ball_on,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       score_l,
    output logic       score_r,
    output logic [1:0] state
);
    localparam int CW = $clog2(SERVE_FRAMES + 1);
    localparam logic [1:0] IDLE = 2'd0, SERVE_WAIT = 2'd1, PLAY = 2'd2, SCORED = 2'd3;
    localparam logic [9:0] X_C = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] Y_C = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic signed [10:0] X_MAX = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic signed [10:0] Y_MAX = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic signed [10:0] XL_EDGE = 11'(PADDLE_X_L + PADDLE_W);
    localparam logic signed [10:0] XR_EDGE = 11'(PADDLE_X_R - BALL_SIZE);
    localparam logic signed [VEL_W-1:0] V_INIT = VEL_W'(VEL_INIT);

    logic [1:0] state_q, state_d;
    logic [9:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic signed [VEL_W-1:0] vx_q, vx_d, vy_q, vy_d, ax, ay, nvx;
    logic serve_dir_q, serve_dir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic vsync_q, ball_on_q, ball_on_d, score_l_q, score_l_d, score_r_q, score_r_d;
    logic frame_tick, launch, ov_l, ov_r, hit_l, hit_r, miss_l, miss_r;
    logic signed [10:0] nx, ny, bx, by;

    assign frame_tick = vsync_q & ~vsync;
    assign launch = frame_tick && cnt_q == CW'(SERVE_FRAMES - 1);
    assign bx = $signed({1'b0, ball_x_q});
    assign by = $signed({1'b0, ball_y_q});
    assign nx = bx + 11'(vx_q);
    assign ny = by + 11'(vy_q);
    assign ax = vx_q < 0 ? -vx_q : vx_q;
    assign ay = vy_q < 0 ? -vy_q : vy_q;
    assign ov_l = ({1'b0, ball_y_q} + 11'(BALL_SIZE) > {1'b0, paddle_l_y}) && ({1'b0, ball_y_q} < {1'b0, paddle_l_y} + 11'(PADDLE_H));
    assign ov_r = ({1'b0, ball_y_q} + 11'(BALL_SIZE) > {1'b0, paddle_r_y}) && ({1'b0, ball_y_q} < {1'b0, paddle_r_y} + 11'(PADDLE_H));
    assign hit_l = vx_q < 0 && bx >= XL_EDGE && nx <= XL_EDGE && ov_l;
    assign hit_r = vx_q > 0 && bx <= XR_EDGE && nx >= XR_EDGE && ov_r;
    assign miss_l = nx <= 11'sd0;
    assign miss_r = nx >= X_MAX;
`ifdef PONG_SPEEDUP_EN
    assign nvx = ax >= VEL_W'(VEL_MAX) ? VEL_W'(VEL_MAX) : ax + VEL_W'(1);
`else
    assign nvx = ax;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ball_x_q    <= X_C;
            ball_y_q    <= Y_C;
            vx_q        <= '0;
            vy_q        <= '0;
            serve_dir_q <= 1'b0;
            cnt_q       <= '0;
            vsync_q     <= 1'b1;
            ball_on_q   <= 1'b0;
            score_l_q   <= 1'b0;
            score_r_q   <= 1'b0;
        end else begin
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            vx_q        <= vx_d;
            vy_q        <= vy_d;
            serve_dir_q <= serve_dir_d;
            cnt_q       <= cnt_d;
            vsync_q     <= vsync;
            ball_on_q   <= ball_on_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       state_d = serve ? SERVE_WAIT : IDLE;
            SERVE_WAIT: state_d = launch ? PLAY : SERVE_WAIT;
            PLAY:       state_d = (frame_tick && !hit_l && !hit_r && (miss_l || miss_r)) ? SCORED : PLAY;
            default:    state_d = frame_tick ? IDLE : SCORED;
        endcase
    end

    always_comb begin
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        vx_d        = vx_q;
        vy_d        = vy_q;
        serve_dir_d = serve_dir_q;
        cnt_d       = cnt_q;
        score_l_d   = 1'b0;
        score_r_d   = 1'b0;
        ball_on_d   = {1'b0, hcount} >= {1'b0, ball_x_q} && {1'b0, hcount} < {1'b0, ball_x_q} + 11'(BALL_SIZE) &&
                      {1'b0, vcount} >= {1'b0, ball_y_q} && {1'b0, vcount} < {1'b0, ball_y_q} + 11'(BALL_SIZE);
        case (state_q)
            IDLE: begin
                ball_x_d = X_C;
                ball_y_d = Y_C;
                vx_d     = '0;
                vy_d     = '0;
                cnt_d    = serve ? '0 : cnt_q;
            end
            SERVE_WAIT: begin
                cnt_d = frame_tick ? cnt_q + CW'(1) : cnt_q;
                vx_d  = launch ? (serve_dir_q ? -V_INIT : V_INIT) : vx_q;
                vy_d  = launch ? V_INIT : vy_q;
            end
            PLAY: if (frame_tick) begin
                ball_y_d = ny <= 11'sd0 ? 10'd0 : ny >= Y_MAX ? Y_MAX[9:0] : ny[9:0];
                vy_d     = ny <= 11'sd0 ? ay : ny >= Y_MAX ? -ay : vy_q;
                // Paddle hits are tested first so a ball meeting a paddle never scores.
                if (hit_l) begin
                    ball_x_d = XL_EDGE[9:0];
                    vx_d     = nvx;
                end else if (hit_r) begin
                    ball_x_d = XR_EDGE[9:0];
                    vx_d     = -nvx;
                end else if (miss_l) begin
                    ball_x_d    = 10'd0;
                    score_r_d   = 1'b1;
                    serve_dir_d = 1'b1;
                    vx_d        = '0;
                    vy_d        = '0;
                end else if (miss_r) begin
                    ball_x_d    = X_MAX[9:0];
                    score_l_d   = 1'b1;
                    serve_dir_d = 1'b0;
                    vx_d        = '0;
                    vy_d        = '0;
                end else begin
                    ball_x_d = nx[9:0];
                end
            end
            default: begin
                vx_d     = '0;
                vy_d     = '0;
                ball_x_d = frame_tick ? X_C : ball_x_q;
                ball_y_d = frame_tick ? Y_C : ball_y_q;
            end
        endcase
    end

    assign ball_on = ball_on_q;
    assign ball_x  = ball_x_q;
    assign ball_y  = ball_y_q;
    assign score_l = score_l_q;
    assign score_r = score_r_q;
    assign state   = state_q;
endmodule
